// File: rtl/traffic_conflict_monitor_if.sv
// Lamp bus between the intersection controller (master) and the conflict monitor (slave).
// Each lamp group is {lt, r, y, g}.
interface traffic_conflict_monitor_if;
    logic       tick;
    logic [3:0] lamp_ns;
    logic [3:0] lamp_sn;
    logic [3:0] lamp_ew;
    logic [3:0] lamp_we;
    logic       clear;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_appr;
    logic       flash_red;

    modport master (
        output tick, lamp_ns, lamp_sn, lamp_ew, lamp_we, clear,
        input  fault, fault_code, fault_appr, flash_red
    );

    modport slave (
        input  tick, lamp_ns, lamp_sn, lamp_ew, lamp_we, clear,
        output fault, fault_code, fault_appr, flash_red
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety watchdog on the intersection lamp outputs: filters steady violations, catches short
// yellows immediately, latches the first cause and requests all-red flash until cleared.
module traffic_conflict_monitor #(
    parameter int FILT_CYC = 4,
    parameter int MIN_YEL  = 5,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    traffic_conflict_monitor_if.slave   bus
);

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_FILTER  = 2'd1;
    localparam logic [1:0] ST_LATCHED = 2'd2;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_BADCOMB  = 3'd2;
    localparam logic [2:0] CODE_SHORTY   = 3'd3;
    localparam logic [2:0] CODE_DARK     = 3'd4;

    localparam logic [CNT_W-1:0] MIN_Y    = CNT_W'(MIN_YEL);
    localparam logic [3:0]       FILT_END = 4'(FILT_CYC);

    // Index 0 = NS, 1 = SN, 2 = EW, 3 = WE
    logic [3:0][3:0] lamp_cur;
    assign lamp_cur = {bus.lamp_we, bus.lamp_ew, bus.lamp_sn, bus.lamp_ns};

    logic [3:0] bad_vec;
    logic [3:0] shorty_vec;
    logic [3:0] dark_vec;
    logic       clr_yel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_appr
        logic             lt_w, r_w, y_w, g_w;
        logic [3:0]       prev_q;
        logic [CNT_W-1:0] yel_q;
        logic [CNT_W-1:0] yel_d;

        assign {lt_w, r_w, y_w, g_w} = lamp_cur[gi];

        assign bad_vec[gi]  = (({1'b0, g_w} + {1'b0, y_w} + {1'b0, r_w}) != 2'd1) | (lt_w & ~r_w);
        assign dark_vec[gi] = ~(g_w | y_w | r_w);
        assign shorty_vec[gi] = (prev_q[1] & ~y_w & r_w & (yel_q < MIN_Y)) |
                                (prev_q[0] & ~g_w & r_w);

        always_comb begin
            yel_d = yel_q;
            if (!y_w)
                yel_d = '0;
            else if (bus.tick && (yel_q < MIN_Y))
                yel_d = yel_q + 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_q <= '0;
                yel_q  <= '0;
            end else begin
                prev_q <= lamp_cur[gi];
                yel_q  <= clr_yel ? '0 : yel_d;
            end
        end
    end

    function automatic logic [1:0] first_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    logic conflict, dark, badcomb, shorty, steady;
    assign conflict = (lamp_cur[0][0] | lamp_cur[1][0] | lamp_cur[0][3] | lamp_cur[1][3]) &
                      (lamp_cur[2][0] | lamp_cur[3][0] | lamp_cur[2][3] | lamp_cur[3][3]);
    assign dark     = &dark_vec;
    assign badcomb  = |bad_vec;
    assign shorty   = |shorty_vec;
    assign steady   = conflict | badcomb | dark;

    // All-dark also makes every approach fail the one-lamp rule; report it as dark, not bad combo.
    logic [2:0] cause_code;
    logic [1:0] cause_appr;
    always_comb begin
        cause_code = CODE_NONE;
        cause_appr = 2'd0;
        if (shorty) begin
            cause_code = CODE_SHORTY;
            cause_appr = first_idx(shorty_vec);
        end else if (conflict) begin
            cause_code = CODE_CONFLICT;
        end else if (dark) begin
            cause_code = CODE_DARK;
        end else if (badcomb) begin
            cause_code = CODE_BADCOMB;
            cause_appr = first_idx(bad_vec);
        end
    end

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [1:0] appr_q, appr_d;
    logic       latch_now;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        code_d    = code_q;
        appr_d    = appr_q;
        clr_yel   = 1'b0;
        latch_now = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (shorty || (steady && FILT_END == 4'd1)) begin
                    latch_now = 1'b1;
                end else if (steady) begin
                    state_d = ST_FILTER;
                    cnt_d   = 4'd1;
                end
            end
            ST_FILTER: begin
                if (shorty || (steady && (cnt_q + 4'd1 == FILT_END))) begin
                    latch_now = 1'b1;
                end else if (steady) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    state_d = ST_ARMED;
                    cnt_d   = 4'd0;
                end
            end
            ST_LATCHED: begin
                if (bus.clear && !steady) begin
                    state_d = ST_ARMED;
                    cnt_d   = 4'd0;
                    fault_d = 1'b0;
                    code_d  = CODE_NONE;
                    appr_d  = 2'd0;
                    clr_yel = 1'b1;
                end
            end
            default: state_d = ST_ARMED;
        endcase
        if (latch_now) begin
            state_d = ST_LATCHED;
            cnt_d   = 4'd0;
            fault_d = 1'b1;
            code_d  = cause_code;
            appr_d  = cause_appr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARMED;
            cnt_q   <= 4'd0;
            fault_q <= 1'b0;
            code_q  <= CODE_NONE;
            appr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            appr_q  <= appr_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.flash_red  = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_appr = appr_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: vector table with a scoreboard queue,
// a looped legal signal cycle and hand-written asynchronous reset sequences.
module tb_traffic_conflict_monitor;

    localparam logic [3:0] R  = 4'b0100;
    localparam logic [3:0] G  = 4'b0001;
    localparam logic [3:0] Y  = 4'b0010;
    localparam logic [3:0] LT = 4'b1100;
    localparam logic [3:0] D  = 4'b0000;

    typedef struct packed {
        logic       f;
        logic [2:0] code;
        logic [1:0] appr;
    } exp_t;

    typedef struct {
        logic       pre_rst;
        logic [3:0] ns, sn, ew, we;
        logic       tk, cl;
        exp_t       e;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    traffic_conflict_monitor_if bus();

    traffic_conflict_monitor #(
        .FILT_CYC(4),
        .MIN_YEL (5),
        .CNT_W   (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic compare(input string name, input exp_t e);
        exp_t act;
        act = '{bus.fault, bus.fault_code, bus.fault_appr};
        checks++;
        if (act !== e || bus.flash_red !== e.f) begin
            failures++;
            $display("FAIL %s: got fault=%0d flash=%0d code=%0d appr=%0d, want fault=%0d code=%0d appr=%0d",
                     name, act.f, bus.flash_red, act.code, act.appr, e.f, e.code, e.appr);
        end
    endtask

    // Drive one clock's worth of inputs; the expected result is queued now and
    // popped once the DUT has taken the edge.
    task automatic drive(input string name, input logic [3:0] ns, sn, ew, we,
                         input logic tk, cl, input exp_t e);
        bus.lamp_ns = ns; bus.lamp_sn = sn; bus.lamp_ew = ew; bus.lamp_we = we;
        bus.tick = tk; bus.clear = cl;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(name, sb_q.pop_front());
        bus.tick = 1'b0; bus.clear = 1'b0;
    endtask

    // Reset is asserted mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset(input string name);
        bus.lamp_ns = R; bus.lamp_sn = R; bus.lamp_ew = R; bus.lamp_we = R;
        bus.tick = 1'b0; bus.clear = 1'b0;
        rst_n = 1'b0;
        #2;
        compare(name, '{1'b0, 3'd0, 2'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic pr, input logic [3:0] ns, sn, ew, we,
                       input logic tk, cl, input logic f, input logic [2:0] c, input logic [1:0] a);
        vec_t v;
        v.pre_rst = pr; v.ns = ns; v.sn = sn; v.ew = ew; v.we = we;
        v.tk = tk; v.cl = cl; v.e = '{f, c, a};
        vecs.push_back(v);
    endtask

    task automatic run_phase(input string name, input logic [3:0] ns, sn, ew, we, input int nticks);
        for (int t = 0; t < nticks; t++) begin
            drive(name, ns, sn, ew, we, 1'b0, 1'b0, '{1'b0, 3'd0, 2'd0});
            drive(name, ns, sn, ew, we, 1'b1, 1'b0, '{1'b0, 3'd0, 2'd0});
        end
        $display("phase %s ticks=%0d fault=%0d", name, nticks, bus.fault);
    endtask

    initial begin
        bus.tick = 1'b0; bus.clear = 1'b0;
        bus.lamp_ns = R; bus.lamp_sn = R; bus.lamp_ew = R; bus.lamp_we = R;
        #2;
        do_reset("reset_state");

        // Legal cycle twice: never a fault
        for (int loop = 0; loop < 2; loop++) begin
            run_phase("ns_green",  G, G, R,  R,  40);
            run_phase("ns_yellow", Y, Y, R,  R,  5);
            run_phase("ew_left",   R, R, LT, LT, 10);
            run_phase("ew_green",  R, R, G,  G,  40);
            run_phase("ew_yellow", R, R, Y,  Y,  5);
        end

        // Conflict via EW left turn for 3 clks, then drop it: filter must not latch
        add(1, G, R, LT, R, 0, 0, 0, 0, 0);
        add(0, G, R, LT, R, 0, 0, 0, 0, 0);
        add(0, G, R, LT, R, 0, 0, 0, 0, 0);
        add(0, G, R, R,  R, 0, 0, 0, 0, 0);
        add(0, G, R, R,  R, 0, 0, 0, 0, 0);
        // ns.g & ew.g for 4 clks: latch on 4th, clear ignored while present
        add(1, G, R, G, R, 0, 0, 0, 0, 0);
        add(0, G, R, G, R, 0, 0, 0, 0, 0);
        add(0, G, R, G, R, 0, 0, 0, 0, 0);
        add(0, G, R, G, R, 0, 0, 1, 1, 0);
        add(0, G, R, G, R, 0, 1, 1, 1, 0);
        add(0, R, R, R, R, 0, 0, 1, 1, 0);
        add(0, R, R, R, R, 0, 1, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 0, 0, 0);
        // Bad combos
        add(1, R, R, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, R, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, R, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, R, R, 4'b1001, 0, 0, 1, 2, 3);
        add(1, R, 4'b0110, R, R, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, R, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, R, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, R, 0, 0, 1, 2, 1);
        add(1, R, 4'b0110, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, 4'b1001, 0, 0, 0, 0, 0);
        add(0, R, 4'b0110, R, 4'b1001, 0, 0, 1, 2, 1);
        // Conflict outranks bad combo
        add(1, G, R, G, 4'b1001, 0, 0, 0, 0, 0);
        add(0, G, R, G, 4'b1001, 0, 0, 0, 0, 0);
        add(0, G, R, G, 4'b1001, 0, 0, 0, 0, 0);
        add(0, G, R, G, 4'b1001, 0, 0, 1, 1, 0);
        // EW yellow 3 ticks then red: short yellow
        add(1, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 1, 3, 2);
        // One tick short of minimum
        add(1, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 1, 3, 2);
        // Exactly minimum, then past saturation
        add(1, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, Y, R, 1, 0, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 0, 0, 0);
        // NS green straight to red
        add(1, G, R, R, R, 0, 0, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 1, 3, 0);
        // Short yellow with a steady bad combo on the same edge: code 3, then frozen
        add(1, G, R, R, R,       0, 0, 0, 0, 0);
        add(0, R, R, R, 4'b1001, 0, 0, 1, 3, 0);
        add(0, R, R, R, 4'b1001, 0, 0, 1, 3, 0);
        add(0, G, R, G, 4'b1001, 0, 0, 1, 3, 0);
        add(0, G, R, G, 4'b1001, 0, 0, 1, 3, 0);
        // All dark
        add(1, D, D, D, D, 0, 0, 0, 0, 0);
        add(0, D, D, D, D, 0, 0, 0, 0, 0);
        add(0, D, D, D, D, 0, 0, 0, 0, 0);
        add(0, D, D, D, D, 0, 0, 1, 4, 0);
        add(0, D, D, D, D, 0, 1, 1, 4, 0);
        add(0, R, R, R, R, 0, 0, 1, 4, 0);
        add(0, R, R, R, R, 0, 1, 0, 0, 0);
        add(0, R, R, R, R, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset($sformatf("vec%0d_reset", i));
            drive($sformatf("vec%0d", i), vecs[i].ns, vecs[i].sn, vecs[i].ew, vecs[i].we,
                  vecs[i].tk, vecs[i].cl, vecs[i].e);
            $display("vec %0d ns=%b sn=%b ew=%b we=%b tick=%0d clr=%0d -> fault=%0d code=%0d appr=%0d",
                     i, vecs[i].ns, vecs[i].sn, vecs[i].ew, vecs[i].we, vecs[i].tk, vecs[i].cl,
                     bus.fault, bus.fault_code, bus.fault_appr);
        end

        // Reset while filtering (cnt=2): the filter must restart from zero afterwards
        do_reset("rst_pre_filter");
        drive("filt_a1", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("filt_a2", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        do_reset("rst_in_filter");
        drive("filt_b1", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("filt_b2", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("filt_b3", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("filt_b4", G, R, G, R, 0, 0, '{1'b1, 3'd1, 2'd0});
        $display("seq reset_in_filter: fault=%0d code=%0d", bus.fault, bus.fault_code);
        // Reset while latched clears at once; a new violation needs the full filter again
        do_reset("rst_in_latched");
        drive("relatch1", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("relatch2", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("relatch3", G, R, G, R, 0, 0, '{1'b0, 3'd0, 2'd0});
        drive("relatch4", G, R, G, R, 0, 0, '{1'b1, 3'd1, 2'd0});
        $display("seq reset_in_latched: fault=%0d code=%0d", bus.fault, bus.fault_code);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
